// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end ahead of IF/ID.
// Owns the fetch PC, keeps at most one imem request outstanding, and buffers
// returned words with their PC+4 in a DEPTH-entry FIFO whose head drives IF/ID.
// Optional build macro IF_PREFETCH_PERF_EN adds saturating bubble/flush counters.

module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_plus_four
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int          CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // IDLE: nothing outstanding; WAIT: live request; DROP: request whose data is stale
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_addr;
    logic          r_req;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc4  [DEPTH];
    logic [CW-1:0] r_rptr, r_wptr;
    logic [CW:0]   r_count, w_count_nxt;
    logic          w_push, w_pop, w_issue, w_cont;
    logic [31:0]   w_pc_plus4, w_redir_pc;

    assign w_pc_plus4  = r_fetch_pc + 32'd4;        // wraps modulo 2^32
    assign w_redir_pc  = redirect_pc & ~32'd3;      // targets are word aligned
    assign inst_valid  = (r_count != '0);
    // Redirect flushes everything, so it suppresses both the push and the pop.
    assign w_push      = (r_state == S_WAIT) && imem_ack && !redirect_valid;
    assign w_pop       = inst_valid && !hold && !redirect_valid;
    assign w_count_nxt = r_count + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};

    assign imem_req          = r_req;
    assign imem_addr         = r_addr;
    assign inst_out          = inst_valid ? r_mem_inst[r_rptr] : 32'h0;
    assign inst_pc_plus_four = inst_valid ? r_mem_pc4[r_rptr]  : 32'h0;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; a new request is issued only when the FIFO can hold its data
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_cont      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!redirect_valid && (r_count < DEPTH_C)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    // Chain the next request only if its data is guaranteed a slot.
                    if (w_count_nxt < DEPTH_C) w_cont = 1'b1;
                    else                       w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch PC and the request port; address is only updated when a request starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
        end else begin
            r_req <= (w_state_nxt != S_IDLE);
            if (redirect_valid) r_fetch_pc <= w_redir_pc;
            else if (w_push)    r_fetch_pc <= w_pc_plus4;
            if (w_issue)        r_addr <= r_fetch_pc;
            else if (w_cont)    r_addr <= w_pc_plus4;
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage; contents are don't-care while the slot is not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= imem_rdata;
            r_mem_pc4[r_wptr]  <= w_pc_plus4;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    // Saturating bubble and flush counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (!inst_valid && !hold && (perf_bubble_cnt != '1))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue. A memory model answers requests and
// checks addresses against an expected-address queue; a monitor checks every
// word IF/ID consumes against an expected-instruction queue.

module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        hold = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    wire         imem_req;
    wire  [31:0] imem_addr;
    wire         inst_valid;
    wire  [31:0] inst_out;
    wire  [31:0] inst_pc_plus_four;
`ifdef IF_PREFETCH_PERF_EN
    wire  [31:0] perf_bubble_cnt;
    wire  [15:0] perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];        // {pc_plus_four, inst}
    logic [31:0] exp_addr_q[$];

    bit          mem_auto  = 1'b0;
    int          lat       = 0;
    int          acks_left = 0;
    int          wcnt      = 0;
    logic        man_ack   = 1'b0;
    logic [31:0] man_data  = 32'h0;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .hold              (hold),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .inst_valid        (inst_valid),
        .inst_out          (inst_out),
        .inst_pc_plus_four (inst_pc_plus_four)
`ifdef IF_PREFETCH_PERF_EN
        ,
        .perf_bubble_cnt   (perf_bubble_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_inst(input logic [31:0] pc4, input logic [31:0] inst);
        exp_q.push_back({pc4, inst});
    endtask

    // Memory model: drives ack/rdata 1 time unit after each falling edge
    always begin : mem_model
        @(negedge clk);
        #1;
        if (!mem_auto) begin
            imem_ack   = man_ack;
            imem_rdata = man_data;
            wcnt       = 0;
        end else if (imem_req && acks_left > 0) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(imem_addr);
                acks_left--;
                wcnt = 0;
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got addr %h want none", imem_addr);
                end else begin
                    chk("imem_addr", imem_addr, exp_addr_q.pop_front());
                end
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    // Monitor: every cycle IF/ID consumes (valid, no hold, no flush) check the head
    always begin : monitor
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (rst_n && inst_valid && !hold && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_inst: got %h want none", inst_out);
            end else begin
                e = exp_q.pop_front();
                chk("inst_out", inst_out, e[31:0]);
                chk("inst_pc4", inst_pc_plus_four, e[63:32]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves reset asserted at a falling edge; caller configures then releases
    task automatic rst_begin();
        @(negedge clk);
        rst_n          = 1'b0;
        hold           = 1'b0;
        redirect_valid = 1'b0;
        man_ack        = 1'b0;
        mem_auto       = 1'b0;
        acks_left      = 0;
        step(2);
    endtask

    task automatic drain_check(input string tag);
        chk({tag, "_left_inst"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_left_addr"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        // A: reset release with same-cycle acks, streaming
        rst_begin();
        chk("A_rst_req", imem_req, 32'd0);
        chk("A_rst_addr", imem_addr, 32'h0);
        chk("A_rst_valid", inst_valid, 32'd0);
        chk("A_rst_inst", inst_out, 32'h0);
        chk("A_rst_pc4", inst_pc_plus_four, 32'h0);
        mem_auto = 1'b1; lat = 0; acks_left = 4;
        exp_addr_q = {32'h0, 32'h4, 32'h8, 32'hC};
        exp_inst(32'h4, 32'hC0DE_0000);
        exp_inst(32'h8, 32'hC0DE_0004);
        exp_inst(32'hC, 32'hC0DE_0008);
        exp_inst(32'h10, 32'hC0DE_000C);
        rst_n = 1'b1;
        step(1);
        chk("A_valid_c1", inst_valid, 32'd0);
        chk("A_req_c1", imem_req, 32'd1);
        step(1);
        chk("A_valid_c2", inst_valid, 32'd1);
        chk("A_pc4_c2", inst_pc_plus_four, 32'h4);
        step(8);
        drain_check("A");

        // B: hold with 3-cycle latency fills exactly DEPTH entries
        rst_begin();
        hold = 1'b1;
        mem_auto = 1'b1; lat = 3; acks_left = 4;
        exp_addr_q = {32'h0, 32'h4, 32'h8, 32'hC};
        exp_inst(32'h4, 32'hC0DE_0000);
        exp_inst(32'h8, 32'hC0DE_0004);
        exp_inst(32'hC, 32'hC0DE_0008);
        exp_inst(32'h10, 32'hC0DE_000C);
        rst_n = 1'b1;
        step(10);
        chk("B_hold_inst_mid", inst_out, 32'hC0DE_0000);
        step(14);
        chk("B_hold_valid", inst_valid, 32'd1);
        chk("B_hold_inst_end", inst_out, 32'hC0DE_0000);
        chk("B_hold_pc4_end", inst_pc_plus_four, 32'h4);
        chk("B_full_no_req", imem_req, 32'd0);
        chk("B_left_addr_full", 32'(exp_addr_q.size()), 32'd0);
        hold = 1'b0;
        step(8);
        drain_check("B");

        // C: redirect while waiting; stale ack two cycles later is discarded
        rst_begin();
        exp_inst(32'h104, 32'hC0DE_0100);
        rst_n = 1'b1;
        step(1);
        chk("C_req", imem_req, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        chk("C_drop_req", imem_req, 32'd1);
        chk("C_drop_addr", imem_addr, 32'h0);
        chk("C_drop_valid", inst_valid, 32'd0);
        step(1);
        man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        step(1);
        man_ack = 1'b0;
        chk("C_idle_req", imem_req, 32'd0);
        mem_auto = 1'b1; lat = 1; acks_left = 1;
        exp_addr_q.push_back(32'h100);
        step(1);
        chk("C_new_addr", imem_addr, 32'h100);
        step(6);
        drain_check("C");

        // D: redirect coincident with ack; low target bits are cleared
        rst_begin();
        exp_inst(32'h204, 32'hC0DE_0200);
        rst_n = 1'b1;
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        man_ack = 1'b1; man_data = 32'h1111_1111;
        step(1);
        redirect_valid = 1'b0; man_ack = 1'b0;
        chk("D_empty", inst_valid, 32'd0);
        chk("D_idle_req", imem_req, 32'd0);
        step(1);
        chk("D_req", imem_req, 32'd1);
        chk("D_addr", imem_addr, 32'h200);
        mem_auto = 1'b1; lat = 0; acks_left = 1;
        exp_addr_q.push_back(32'h200);
        step(5);
        drain_check("D");

        // E: PC wrap from 0xFFFFFFFC to 0
        rst_begin();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        mem_auto = 1'b1; lat = 0; acks_left = 2;
        exp_addr_q = {32'hFFFF_FFFC, 32'h0};
        exp_inst(32'h0, 32'hC0DE_FFFC);
        exp_inst(32'h4, 32'hC0DE_0000);
        rst_n = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        chk("E_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(1);
        chk("E_addr_wrap", imem_addr, 32'h0);
        chk("E_valid", inst_valid, 32'd1);
        chk("E_pc4_wrap", inst_pc_plus_four, 32'h0);
        step(5);
        drain_check("E");

        // F: asynchronous reset mid-request, stray ack afterwards is ignored
        rst_begin();
        rst_n = 1'b1;
        step(1);
        chk("F_req", imem_req, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("F_async_req", imem_req, 32'd0);
        chk("F_async_addr", imem_addr, 32'h0);
        chk("F_async_valid", inst_valid, 32'd0);
        chk("F_async_inst", inst_out, 32'h0);
        chk("F_async_pc4", inst_pc_plus_four, 32'h0);
        man_ack = 1'b1; man_data = 32'hBAD0_BAD0;
        step(2);
        rst_n = 1'b1;
        step(1);
        man_ack = 1'b0;
        chk("F_stray_valid", inst_valid, 32'd0);
        chk("F_new_req", imem_req, 32'd1);
        chk("F_new_addr", imem_addr, 32'h0);
        step(1);
        chk("F_stray_valid2", inst_valid, 32'd0);
        drain_check("F");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
